// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and the return register (RR).
// Priority per edge: reset, stall (hold), redirect (flush), sequential fetch; RR is written independently.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        rr_we,
  input  logic [15:0] rr_wdata,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic [15:0] rr
);

  logic [15:0] pc_r;
  logic [15:0] instr_r;
  logic [15:0] pc1_r;
  logic        valid_r;
  logic [15:0] rr_r;

  logic [15:0] pc_inc_s;
  logic [15:0] pc_nxt_s;
  logic [15:0] instr_nxt_s;
  logic [15:0] pc1_nxt_s;
  logic        valid_nxt_s;

  // Sequential PC wraps naturally at 16 bits.
  assign pc_inc_s = pc_r + 16'd1;

  // Next-state selection for PC and IF/ID.
  always_comb begin
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    pc1_nxt_s   = pc1_r;
    valid_nxt_s = valid_r;
    if (stall) begin
      // redirect is ignored here; decode re-presents it once the hazard clears
      pc_nxt_s    = pc_r;
      instr_nxt_s = instr_r;
      pc1_nxt_s   = pc1_r;
      valid_nxt_s = valid_r;
    end else if (redirect) begin
      pc_nxt_s    = redirect_pc;
      instr_nxt_s = NOP_INSTR;
      pc1_nxt_s   = 16'h0000;
      valid_nxt_s = 1'b0;
    end else begin
      pc_nxt_s    = pc_inc_s;
      instr_nxt_s = imem_rdata;
      pc1_nxt_s   = pc_inc_s;
      valid_nxt_s = 1'b1;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      instr_r <= NOP_INSTR;
      pc1_r   <= 16'h0000;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      instr_r <= instr_nxt_s;
      pc1_r   <= pc1_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Return register, written regardless of stall/redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_r <= 16'h0000;
    end else if (rr_we) begin
      rr_r <= rr_wdata;
    end else begin
      rr_r <= rr_r;
    end
  end

  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign if_id_instr = instr_r;
  assign if_id_pc1   = pc1_r;
  assign if_id_valid = valid_r;
  assign rr          = rr_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, fetch, redirect, stall priority, RR, wrap.
// Instruction memory is a pure function of address so every expected word is known up front.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        rr_we;
  logic [15:0] rr_wdata;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic [15:0] rr;

  int n_checks;
  int n_fails;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rr_we       (rr_we),
    .rr_wdata    (rr_wdata),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid),
    .rr          (rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program at 0..2 from the test plan; elsewhere addr ^ 16'h5A00.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1001;
      16'h0001: mem_word = 16'h1002;
      16'h0002: mem_word = 16'h1003;
      default:  mem_word = a ^ 16'h5A00;
    endcase
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                           input logic [15:0] e_pc1, input logic e_valid);
    check_eq({tag, ".pc"},    pc,          e_pc);
    check_eq({tag, ".addr"},  imem_addr,   e_pc);
    check_eq({tag, ".instr"}, if_id_instr, e_instr);
    check_eq({tag, ".pc1"},   if_id_pc1,   e_pc1);
    check_eq({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, e_valid});
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    rr_we       = 1'b0;
    rr_wdata    = 16'h0000;

    // Reset then run
    step();
    step();
    check_all("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check_eq("rst.rr", rr, 16'h0000);
    reset = 1'b0;
    step();
    check_all("run0", 16'h0001, 16'h1001, 16'h0001, 1'b1);
    step();
    check_all("run1", 16'h0002, 16'h1002, 16'h0002, 1'b1);
    step();
    check_all("run2", 16'h0003, 16'h1003, 16'h0003, 1'b1);
    step();
    step();
    check_all("run4", 16'h0005, 16'h5A04, 16'h0005, 1'b1);

    // Redirect/flush at pc=5
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    check_all("redir", 16'h0040, 16'h0000, 16'h0000, 1'b0);
    redirect = 1'b0;
    step();
    check_all("redir_tgt", 16'h0041, 16'h5A40, 16'h0041, 1'b1);

    // Reach pc=8 with a valid word in IF/ID
    redirect    = 1'b1;
    redirect_pc = 16'h0007;
    step();
    redirect = 1'b0;
    step();
    check_all("pre_stall", 16'h0008, 16'h5A07, 16'h0008, 1'b1);

    // Stall beats redirect for 3 cycles; rr still writes
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0020;
    rr_we       = 1'b1;
    rr_wdata    = 16'h0077;
    step();
    check_all("stall0", 16'h0008, 16'h5A07, 16'h0008, 1'b1);
    check_eq("stall_rr", rr, 16'h0077);
    rr_we = 1'b0;
    step();
    check_all("stall1", 16'h0008, 16'h5A07, 16'h0008, 1'b1);
    step();
    check_all("stall2", 16'h0008, 16'h5A07, 16'h0008, 1'b1);
    stall = 1'b0;
    step();
    check_all("post_stall", 16'h0020, 16'h0000, 16'h0000, 1'b0);
    check_eq("rr_hold", rr, 16'h0077);

    // CALL: rr write and redirect on same edge
    rr_we       = 1'b1;
    rr_wdata    = 16'h0013;
    redirect_pc = 16'h0100;
    step();
    check_eq("call.rr", rr, 16'h0013);
    check_eq("call.pc", pc, 16'h0100);
    rr_we    = 1'b0;
    redirect = 1'b0;
    step();
    check_all("call_tgt", 16'h0101, 16'h5B00, 16'h0101, 1'b1);

    // Wrap
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    check_eq("wrap.pc_ffff", pc, 16'hFFFF);
    redirect = 1'b0;
    step();
    check_all("wrap", 16'h0000, 16'hA5FF, 16'h0000, 1'b1);

    // Reset mid-operation during a stall
    rr_we    = 1'b1;
    rr_wdata = 16'hABCD;
    step();
    check_eq("mid.rr", rr, 16'hABCD);
    rr_we = 1'b0;
    stall = 1'b1;
    step();
    check_eq("mid.stall_pc", pc, 16'h0001);
    reset       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    rr_we       = 1'b1;
    rr_wdata    = 16'h1234;
    step();
    check_all("mid_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check_eq("mid_rst.rr", rr, 16'h0000);
    reset    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    rr_we    = 1'b0;
    step();
    check_all("after_rst", 16'h0001, 16'h1001, 16'h0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined processor. It holds the PC, drives the instruction-memory address, and latches the fetched word and its PC+1 for the decode stage, where the main controller decodes the 4-bit opcode and 3-bit function. It also owns the return register (RR) used by CALL, FOR and RET. It applies the stall and redirect requests that decode produces from its Branch, BNE, JMP, SelectPCSrc and UpdateRR decisions.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word inserted into IF/ID on reset and on flush.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  16  instruction-memory word address; combinationally equal to pc.
- imem_rdata  input  16  instruction word at imem_addr; combinational read, valid in the same cycle.
- stall  input  1  freeze request from decode (load-use hazard).
- redirect  input  1  taken branch, jump, CALL, RET or FOR loop-back, resolved in decode.
- redirect_pc  input  16  target PC, valid when redirect=1.
- rr_we  input  1  RR write enable; decode asserts it only for a valid, unstalled UpdateRR instruction.
- rr_wdata  input  16  value written to RR.
- pc  output  16  current fetch PC (register).
- if_id_instr  output  16  latched instruction word for decode.
- if_id_pc1  output  16  PC+1 of the latched instruction.
- if_id_valid  output  1  1 = latched instruction is real; 0 = bubble.
- rr  output  16  return register (register output, no bypass).

## Operation
- The PC is word-addressed; the sequential next PC is pc+1, 16-bit modulo (16'hFFFF wraps to 16'h0000).
- One action per rising edge, in priority order:
  1. **reset=1:** pc←RESET_PC, if_id_instr←NOP_INSTR, if_id_pc1←0, if_id_valid←0, rr←0. Stall, redirect and rr_we are ignored.
  2. **stall=1:** pc, if_id_instr, if_id_pc1 and if_id_valid all hold. redirect is ignored because decode re-evaluates it once operands are ready.
  3. **redirect=1 (stall=0):** pc←redirect_pc. IF/ID is flushed: if_id_instr←NOP_INSTR, if_id_valid←0, if_id_pc1←0. The word fetched this cycle is discarded.
  4. **Otherwise:** if_id_instr←imem_rdata, if_id_pc1←pc+1, if_id_valid←1, pc←pc+1.
- RR is independent of stall and redirect. If rr_we=1 and reset=0, then rr←rr_wdata on the edge.
- A CALL whose decode cycle asserts both rr_we and redirect writes RR and redirects on the same edge.
- A RET in decode reads the registered rr. An RR write becomes visible on the cycle after the edge that performs it.
- Bubbles (if_id_valid=0) carry NOP_INSTR. Decode must suppress all writes, redirects and rr_we for invalid instructions.
- The PC is only ever changed by reset, redirect or increment. There are no other state machines.

## Timing
- All outputs are registered except imem_addr, which is a wire copy of pc.
- Fetch-to-decode latency is 1 cycle: a word read at PC p appears on if_id_instr on the next edge, with if_id_pc1=p+1.
- Redirect penalty is 1 bubble. With redirect asserted in cycle n, the target is fetched in cycle n+1 and is valid in IF/ID at cycle n+2.
- Stall holds everything for exactly as many cycles as stall is high. The cycle after stall drops proceeds normally, including any redirect presented then.
- Reset is honored mid-operation on any edge. The first valid instruction appears in IF/ID one edge after the first cycle with reset=0.
- No combinational path from any input to any output other than pc→imem_addr.

## Test plan
- **Reset then run:** assert reset 2 cycles, then release with imem holding 16'h1001, 16'h1002, 16'h1003 at 0, 1, 2 → pc steps 0→1→2→3. IF/ID shows (16'h1001, pc1=1, valid=1), then (16'h1002, 2), then (16'h1003, 3). The cycle after release shows valid=0 and instr=16'h0000.
- **Redirect/flush:** at pc=5 assert redirect with redirect_pc=16'h0040 → next edge: pc=16'h0040, valid=0, instr=16'h0000. The following edge latches mem[16'h0040] with pc1=16'h0041.
- **Stall priority:** at pc=8 hold stall=1 for 3 cycles with redirect=1 and redirect_pc=16'h0020 throughout → pc stays 8 and IF/ID is unchanged. On the first cycle with stall=0 and redirect=1, pc becomes 16'h0020.
- **RR:** rr_we=1 with rr_wdata=16'h0013 together with redirect to 16'h0100 → the same edge gives rr=16'h0013 and pc=16'h0100. rr_we=1 under stall=1 still updates rr.
- **Wrap:** force pc=16'hFFFF via redirect, then run freely → IF/ID pc1=16'h0000 and pc=16'h0000.
- **Reset mid-operation:** assert reset during a stall with rr=16'hABCD → next edge gives pc=RESET_PC, valid=0, rr=0.
